// File: rtl/ula_pkg.sv
// Shared constants and helpers for the ula_8bits ALU.
//   - Mode constants (arithmetic / logic).
//   - 4-bit function-select codes for each mode.
//   - is_sub_op(): flags the codes whose carry-out is reported as a borrow.
package ula_pkg;

  localparam logic MODE_ARIT  = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // Arithmetic-mode codes (every result also adds c_in)
  localparam logic [3:0] ARIT_A          = 4'b0000;
  localparam logic [3:0] ARIT_A_OR_B     = 4'b0001;
  localparam logic [3:0] ARIT_A_OR_NB    = 4'b0010;
  localparam logic [3:0] ARIT_MINUS1     = 4'b0011;
  localparam logic [3:0] ARIT_A_P_ANB    = 4'b0100;
  localparam logic [3:0] ARIT_AOB_P_ANB  = 4'b0101;
  localparam logic [3:0] ARIT_A_M_B_M1   = 4'b0110;
  localparam logic [3:0] ARIT_ANB_M1     = 4'b0111;
  localparam logic [3:0] ARIT_A_P_AB     = 4'b1000;
  localparam logic [3:0] ARIT_A_P_B      = 4'b1001;
  localparam logic [3:0] ARIT_AONB_P_AB  = 4'b1010;
  localparam logic [3:0] ARIT_AB_M1      = 4'b1011;
  localparam logic [3:0] ARIT_A_P_A      = 4'b1100;
  localparam logic [3:0] ARIT_AOB_P_A    = 4'b1101;
  localparam logic [3:0] ARIT_AONB_P_A   = 4'b1110;
  localparam logic [3:0] ARIT_A_M1       = 4'b1111;

  // Logic-mode codes
  localparam logic [3:0] LOGIC_NOT_A     = 4'b0000;
  localparam logic [3:0] LOGIC_NOR       = 4'b0001;
  localparam logic [3:0] LOGIC_NA_AND_B  = 4'b0010;
  localparam logic [3:0] LOGIC_ZERO      = 4'b0011;
  localparam logic [3:0] LOGIC_NAND      = 4'b0100;
  localparam logic [3:0] LOGIC_NOT_B     = 4'b0101;
  localparam logic [3:0] LOGIC_XOR       = 4'b0110;
  localparam logic [3:0] LOGIC_A_AND_NB  = 4'b0111;
  localparam logic [3:0] LOGIC_NA_OR_B   = 4'b1000;
  localparam logic [3:0] LOGIC_XNOR      = 4'b1001;
  localparam logic [3:0] LOGIC_B         = 4'b1010;
  localparam logic [3:0] LOGIC_AND       = 4'b1011;
  localparam logic [3:0] LOGIC_ONES      = 4'b1100;
  localparam logic [3:0] LOGIC_A_OR_NB   = 4'b1101;
  localparam logic [3:0] LOGIC_OR        = 4'b1110;
  localparam logic [3:0] LOGIC_A         = 4'b1111;

  // Codes whose result is a subtraction; their carry-out is inverted into a borrow.
  function automatic logic is_sub_op(input logic [3:0] s);
    return (s == ARIT_MINUS1)   || (s == ARIT_A_M_B_M1) || (s == ARIT_ANB_M1) ||
           (s == ARIT_AB_M1)    || (s == ARIT_A_M1);
  endfunction

endpackage

// File: rtl/ula_slice4.sv
// One 4-bit 74181-style slice.
//   a, b   : operand nibbles
//   s, m   : function select and mode (0 = arithmetic, 1 = logic)
//   c_in   : carry into this nibble (ignored in logic mode)
//   f      : result nibble
//   c_out  : natural (non-inverted) carry out of bit 3; 0 in logic mode
module ula_slice4
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;

  always_comb begin
    x   = a | (s[0] ? b : 4'h0) | (s[1] ? ~b : 4'h0);
    y   = (s[2] ? (a & ~b) : 4'h0) | (s[3] ? (a & b) : 4'h0);
    sum = {1'b0, x} + {1'b0, y} + {4'h0, c_in};
  end

  always_comb begin
    f     = 4'h0;
    c_out = 1'b0;
    if (m == MODE_ARIT) begin
      f     = sum[3:0];
      c_out = sum[4];
    end else begin
      unique case (s)
        LOGIC_NOT_A:    f = ~a;
        LOGIC_NOR:      f = ~(a | b);
        LOGIC_NA_AND_B: f = ~a & b;
        LOGIC_ZERO:     f = 4'h0;
        LOGIC_NAND:     f = ~(a & b);
        LOGIC_NOT_B:    f = ~b;
        LOGIC_XOR:      f = a ^ b;
        LOGIC_A_AND_NB: f = a & ~b;
        LOGIC_NA_OR_B:  f = ~a | b;
        LOGIC_XNOR:     f = ~(a ^ b);
        LOGIC_B:        f = b;
        LOGIC_AND:      f = a & b;
        LOGIC_ONES:     f = 4'hF;
        LOGIC_A_OR_NB:  f = a | ~b;
        LOGIC_OR:       f = a | b;
        LOGIC_A:        f = a;
        default:        f = 4'h0;
      endcase
    end
  end

endmodule

// File: rtl/ula_8bits.sv
// 74181-compatible ALU, WIDTH bits wide (multiple of 4), built from ripple-chained
// 4-bit slices, with a registered copy of its outputs.
//   clk, rst_n        : clock and asynchronous active-low reset (registered outputs only)
//   a, b              : operands
//   s, m, c_in        : function select, mode (0 arith / 1 logic), carry-in
//   en                : capture enable for the registered outputs
//   f, c_out, a_eq_b  : combinational result, carry/borrow, all-ones flag
//   f_q, c_out_q, a_eq_b_q : registered copies (1-cycle latency)
module ula_8bits
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  input  logic             en,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b,
  output logic [WIDTH-1:0] f_q,
  output logic             c_out_q,
  output logic             a_eq_b_q
);

  localparam int unsigned NSlice = WIDTH / 4;

  logic [NSlice:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < NSlice; i++) begin : g_slice
    ula_slice4 u_slice (
      .a     (a[4*i +: 4]),
      .b     (b[4*i +: 4]),
      .s     (s),
      .m     (m),
      .c_in  (carry[i]),
      .f     (f[4*i +: 4]),
      .c_out (carry[i+1])
    );
  end

  always_comb begin
    c_out = 1'b0;
    if (m == MODE_ARIT) begin
      // Subtract-class codes report a borrow rather than a carry.
      c_out = is_sub_op(s) ? ~carry[NSlice] : carry[NSlice];
    end
  end

  assign a_eq_b = &f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q      <= '0;
      c_out_q  <= 1'b0;
      a_eq_b_q <= 1'b0;
    end else if (en) begin
      f_q      <= f;
      c_out_q  <= c_out;
      a_eq_b_q <= a_eq_b;
    end
  end

endmodule

// File: tb/tb_ula_8bits.sv
module tb_ula_8bits;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] s;
  logic       m;
  logic       c_in;
  logic       en;
  logic [7:0] f;
  logic       c_out;
  logic       a_eq_b;
  logic [7:0] f_q;
  logic       c_out_q;
  logic       a_eq_b_q;

  int n_tests = 0;
  int n_fail  = 0;

  ula_8bits #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .s        (s),
    .m        (m),
    .c_in     (c_in),
    .en       (en),
    .f        (f),
    .c_out    (c_out),
    .a_eq_b   (a_eq_b),
    .f_q      (f_q),
    .c_out_q  (c_out_q),
    .a_eq_b_q (a_eq_b_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {f, c_out, a_eq_b} from the defining equations on whole bytes.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic [3:0] ms, input logic mm,
                                       input logic mc);
    logic [7:0] x, y, rf;
    logic [8:0] sum;
    logic       rc;
    bit         sub;
    if (!mm) begin
      x   = ma | (ms[0] ? mb : 8'h00) | (ms[1] ? ~mb : 8'h00);
      y   = (ms[2] ? (ma & ~mb) : 8'h00) | (ms[3] ? (ma & mb) : 8'h00);
      sum = 9'(x) + 9'(y) + 9'(mc);
      rf  = sum[7:0];
      sub = (ms == 4'h3) || (ms == 4'h6) || (ms == 4'h7) || (ms == 4'hB) || (ms == 4'hF);
      rc  = sub ? ~sum[8] : sum[8];
    end else begin
      rc = 1'b0;
      case (ms)
        4'h0: rf = ~ma;
        4'h1: rf = ~(ma | mb);
        4'h2: rf = ~ma & mb;
        4'h3: rf = 8'h00;
        4'h4: rf = ~(ma & mb);
        4'h5: rf = ~mb;
        4'h6: rf = ma ^ mb;
        4'h7: rf = ma & ~mb;
        4'h8: rf = ~ma | mb;
        4'h9: rf = ~(ma ^ mb);
        4'hA: rf = mb;
        4'hB: rf = ma & mb;
        4'hC: rf = 8'hFF;
        4'hD: rf = ma | ~mb;
        4'hE: rf = ma | mb;
        default: rf = ma;
      endcase
    end
    return {rf, rc, (rf == 8'hFF)};
  endfunction

  // Expected registered outputs
  logic [9:0] exp_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= '0;
    else if (en) exp_q <= model(a, b, s, m, c_in);
  end

  // Cycle-by-cycle compare on the falling edge
  always @(negedge clk) begin
    logic [9:0] e;
    e = model(a, b, s, m, c_in);
    n_tests++;
    if ({f, c_out, a_eq_b} !== e) begin
      n_fail++;
      $display("FAIL comb s=%h m=%b a=%h b=%h ci=%b: got f=%h c=%b eq=%b, want f=%h c=%b eq=%b",
               s, m, a, b, c_in, f, c_out, a_eq_b, e[9:2], e[1], e[0]);
    end
    n_tests++;
    if ({f_q, c_out_q, a_eq_b_q} !== exp_q) begin
      n_fail++;
      $display("FAIL regs: got f_q=%h c_q=%b eq_q=%b, want f_q=%h c_q=%b eq_q=%b",
               f_q, c_out_q, a_eq_b_q, exp_q[9:2], exp_q[1], exp_q[0]);
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Directed vector: literal expectations checked against both the DUT and the model.
  task automatic vec(input string name, input logic [7:0] va, input logic [7:0] vb,
                     input logic [3:0] vs, input logic vm, input logic vc,
                     input logic [7:0] ef, input logic ec);
    logic [9:0] e;
    @(posedge clk);
    #2;
    a = va; b = vb; s = vs; m = vm; c_in = vc;
    #1;
    e = model(va, vb, vs, vm, vc);
    check({name, " f"}, f, ef);
    check({name, " c_out"}, {7'd0, c_out}, {7'd0, ec});
    check({name, " a_eq_b"}, {7'd0, a_eq_b}, {7'd0, (ef == 8'hFF)});
    check({name, " model"}, {e[9:2]}, ef);
  endtask

  logic [7:0] sweep [16] = '{8'hA5, 8'h84, 8'h21, 8'h00, 8'hED, 8'hCC, 8'h69, 8'h48,
                             8'hB7, 8'h96, 8'h33, 8'h12, 8'hFF, 8'hDE, 8'h7B, 8'h5A};

  initial begin
    rst_n = 1'b0; en = 1'b1;
    a = 8'h00; b = 8'h00; s = 4'h0; m = 1'b0; c_in = 1'b0;
    #1;
    check("reset f_q", f_q, 8'h00);
    check("reset flags_q", {6'd0, c_out_q, a_eq_b_q}, 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b1;

    vec("add a+1",    8'hFF, 8'h00, 4'b0000, 1'b0, 1'b1, 8'h00, 1'b1);
    vec("a|b+b&a+1",  8'h03, 8'hC0, 4'b1001, 1'b0, 1'b1, 8'hC4, 1'b0);
    vec("a+a",        8'hC3, 8'h00, 4'b1100, 1'b0, 1'b0, 8'h86, 1'b1);
    vec("minus1",     8'h00, 8'h00, 4'b0011, 1'b0, 1'b0, 8'hFF, 1'b1);
    vec("minus1+1",   8'h00, 8'h00, 4'b0011, 1'b0, 1'b1, 8'h00, 1'b0);
    vec("a-b-1",      8'hC3, 8'h42, 4'b0110, 1'b0, 1'b0, 8'h80, 1'b0);
    vec("a&~b-1",     8'h33, 8'h11, 4'b0111, 1'b0, 1'b0, 8'h21, 1'b0);
    vec("a-1",        8'hC3, 8'h00, 4'b1111, 1'b0, 1'b0, 8'hC2, 1'b0);
    vec("a|b+a&~b",   8'h36, 8'hF0, 4'b0101, 1'b0, 1'b0, 8'hFC, 1'b0);
    vec("a|~b+a+1",   8'hC3, 8'hF0, 4'b1110, 1'b0, 1'b1, 8'h93, 1'b1);
    vec("a|~b+ab+1",  8'h11, 8'h00, 4'b1010, 1'b0, 1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      vec($sformatf("logic s=%0d", i), 8'h5A, 8'h33, 4'(i), 1'b1, 1'b1, sweep[i], 1'b0);
    end
    vec("eq equal",   8'h77, 8'h77, 4'b0110, 1'b0, 1'b0, 8'hFF, 1'b1);
    vec("eq differ",  8'h78, 8'h77, 4'b0110, 1'b0, 1'b0, 8'h00, 1'b0);

    // Asynchronous reset mid-operation: registers clear at once, f unaffected
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async rst f_q", f_q, 8'h00);
    check("async rst flags_q", {6'd0, c_out_q, a_eq_b_q}, 8'h00);
    check("async rst f", f, 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Capture and hold
    vec("capture vec", 8'h03, 8'hC0, 4'b1001, 1'b0, 1'b0, 8'hC3, 1'b0);
    @(posedge clk); #1;
    check("capture f_q", f_q, 8'hC3);
    #1;
    en = 1'b0;
    a = 8'h12; b = 8'h34; s = 4'b0110; m = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold f_q", f_q, 8'hC3);
    check("hold flags_q", {6'd0, c_out_q, a_eq_b_q}, 8'h00);

    // Reset dominates en
    en = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst over en f_q", f_q, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_8bits.md
Name: ula_8bits

Overview:
- 8-bit ALU implementing the 74181 function set with active-high data and an active-high carry-in: 16 arithmetic functions (m=0) and 16 logic functions (m=1).
- Primary outputs f, c_out and a_eq_b are purely combinational.
- A registered copy of the outputs is captured on clk for pipelined consumers.
- Sits in the datapath as a general-purpose execution unit.

Parameters:
- WIDTH, 8, operand/result width; must be a multiple of 4 (one 4-bit slice per nibble).

Ports:
- clk  input  1  clock; only the registered outputs use it.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s  input  4  function select.
- m  input  1  mode: 0 = arithmetic, 1 = logic.
- c_in  input  1  carry-in, active-high; adds 1 in arithmetic mode.
- en  input  1  capture enable for the registered outputs.
- f  output  WIDTH  combinational result.
- c_out  output  1  combinational carry/borrow out.
- a_eq_b  output  1  combinational, high when f is all ones.
- f_q  output  WIDTH  registered f.
- c_out_q  output  1  registered c_out.
- a_eq_b_q  output  1  registered a_eq_b.

Behaviour:
- Arithmetic mode (m=0): f = X + Y + c_in, truncated to WIDTH bits.
  - X = A | (s[0] ? B : 0) | (s[1] ? ~B : 0).
  - Y = (s[2] ? A&~B : 0) | (s[3] ? A&B : 0).
- Resulting arithmetic functions by s:
  - 0000: A
  - 0001: A|B
  - 0010: A|~B
  - 0011: minus 1
  - 0100: A+(A&~B)
  - 0101: (A|B)+(A&~B)
  - 0110: A-B-1
  - 0111: (A&~B)-1
  - 1000: A+(A&B)
  - 1001: A+B
  - 1010: (A|~B)+(A&B)
  - 1011: (A&B)-1
  - 1100: A+A
  - 1101: (A|B)+A
  - 1110: (A|~B)+A
  - 1111: A-1
  - Every one of these also adds c_in.
- Arithmetic c_out:
  - Let cy = carry out of bit WIDTH-1 of X+Y+c_in.
  - For the subtract-class codes s ∈ {0011, 0110, 0111, 1011, 1111}: c_out = ~cy, i.e. a borrow flag.
  - For all other codes: c_out = cy.
- Logic mode (m=1): bitwise function, c_in ignored, c_out = 0.
  - 0000: ~A
  - 0001: ~(A|B)
  - 0010: ~A&B
  - 0011: 0
  - 0100: ~(A&B)
  - 0101: ~B
  - 0110: A^B
  - 0111: A&~B
  - 1000: ~A|B
  - 1001: ~(A^B)
  - 1010: B
  - 1011: A&B
  - 1100: all ones
  - 1101: A|~B
  - 1110: A|B
  - 1111: A
- a_eq_b = &f in both modes. With m=0, s=0110, c_in=0 it flags A==B.
- Combinational outputs settle within the same delta/timestep as any input change and do not depend on clk, rst_n or en.
- No X propagation beyond the inputs: a fully known input set must give a fully known output set.
- Registered outputs:
  - On rst_n low (asynchronous): f_q=0, c_out_q=0, a_eq_b_q=0.
  - On posedge clk with en=1: capture f, c_out, a_eq_b; with en=0: hold.
  - Latency is 1 cycle.
  - Reset asserted mid-operation clears the registered outputs immediately; the combinational outputs are unaffected.
  - Reset dominates en.

Decomposition:
- Package ula_pkg:
  - mode constants MODE_ARIT=0, MODE_LOGIC=1.
  - 4-bit function-code constants for all 16 s values, one set per mode.
  - function is_sub_op(s) returning 1 for the five subtract-class codes.
- Sub-module ula_slice4:
  - one 4-bit 74181-style slice taking a, b, s, m, carry-in; producing f nibble and natural carry-out.
  - Instantiated WIDTH/4 times with ripple carry.
  - Top level applies borrow inversion, a_eq_b and the output registers.

Test Plan:
- Add/carry: m=0.
  - s=0000, a=FF, c_in=1 -> f=00, c_out=1.
  - s=1001, a=03, b=C0, c_in=1 -> f=C4, c_out=0.
  - s=1100, a=C3 -> f=86, c_out=1.
- Borrow class: m=0.
  - s=0011, c_in=0 -> f=FF, c_out=1.
  - s=0011, c_in=1 -> f=00, c_out=0.
  - s=0110, a=C3, b=42, c_in=0 -> f=80, c_out=0.
  - s=0111, a=33, b=11 -> f=21, c_out=0.
  - s=1111, a=C3 -> f=C2, c_out=0.
- Mixed terms: m=0.
  - s=0101, a=36, b=F0 -> f=FC, c_out=0.
  - s=1110, a=C3, b=F0, c_in=1 -> f=93, c_out=1.
  - s=1010, a=11, b=00, c_in=1 -> f=00, c_out=1.
- Logic sweep: m=1, a=5A, b=33, all 16 s.
  - Required f per s: A5, 84, 21, 00, ED, CC, 69, 48, B7, 96, 33, 12, FF, DE, 7B, 5A.
  - c_out=0 in every case.
- Equality flag:
  - m=0, s=0110, c_in=0, a=b=77 -> f=FF, a_eq_b=1.
  - a=78, b=77 -> f=00, a_eq_b=0.
- Registers:
  - rst_n=0 asynchronously -> *_q=0 without a clock edge.
  - Release reset, en=1, a=03, b=C0, s=1001, m=0 -> f_q=C3 after one clk edge.
  - en=0, change inputs -> f_q holds C3.
